// File: rtl/event_encoder_pkg.sv
// Shared definitions for the event encoder: widths, FSM states and the
// index-to-one-hot mapping used by the matching 3-to-8 decoder.
package event_encoder_pkg;

   // Request vector width and digit width (digit width = clog2 of vector width).
   localparam int EV_N = 8;
   localparam int EV_W = 3;

   // Encoder FSM: IDLE while nothing is offered, OFFER while valid is high.
   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // Same mapping as the 3-to-8 decoder: digit d selects bit d.
   function automatic logic [EV_N-1:0] onehot(input logic [EV_W-1:0] d);
      logic [EV_N-1:0] r;
      r    = '0;
      r[d] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/event_encoder_prio_enc8.sv
// Combinational lowest-set-bit encoder for an 8-bit vector.
// Bit 0 has the highest priority; idx is 0 when nothing is set.
module prio_enc8 (
   input  logic [7:0] in,
   output logic [2:0] idx,
   output logic       any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = 3'd0;
      any = |in;
      for (int i = 7; i >= 0; i--) begin
         if (in[i]) begin
            idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/event_encoder.sv
// Sequential 8-to-3 event encoder. Requests on vector are latched into a
// pending bitmap; the lowest pending index is offered on digit under a
// valid/ready handshake and its bit is cleared once accepted.
//
// Handshake: digit is offered while valid=1 and is held stable until the
// cycle in which ready=1; that cycle is the transfer (valid & ready). valid
// and digit are registered and never depend on ready or vector in the same
// cycle. A new request on a bit that is being accepted in the same cycle
// keeps the bit pending (set wins) and is offered again later.
module event_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] vector,
   output logic [W-1:0] digit,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         overflow,
   output logic         fsm_state
);

   import event_encoder_pkg::*;

   state_t         state_q;
   state_t         state_d;
   logic [W-1:0]   digit_q;
   logic [W-1:0]   digit_d;
   logic [N-1:0]   pending_q;
   logic [N-1:0]   pending_d;
   logic           overflow_q;
   logic           overflow_d;

   logic           accept;
   logic [N-1:0]   clr;
   logic [N-1:0]   rem;
   logic [W-1:0]   pend_idx;
   logic           pend_any;
   logic [W-1:0]   rem_idx;
   logic           rem_any;

   // valid is a decode of the registered state, so it is itself registered.
   assign valid     = (state_q == OFFER);
   assign digit     = digit_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;
   assign fsm_state = state_q;

   assign accept = valid & ready;

   // Bits still pending once the currently offered one is taken away.
   // Requests arriving this cycle are deliberately not included.
   assign rem = pending_q & ~onehot(digit_q);

   // Lowest pending index, used when leaving IDLE.
   prio_enc8 u_prio_pending (
      .in  (pending_q),
      .idx (pend_idx),
      .any (pend_any)
   );

   // Lowest remaining index, used for back-to-back offers.
   prio_enc8 u_prio_rem (
      .in  (rem),
      .idx (rem_idx),
      .any (rem_any)
   );

   // Pending bitmap and overflow: clear the accepted bit, then OR in new
   // requests so a same-cycle re-request wins over the clear.
   always_comb begin
      clr        = '0;
      if (accept) begin
         clr = onehot(digit_q);
      end
      pending_d  = (pending_q & ~clr) | vector;
      overflow_d = |(vector & pending_q & ~clr);
   end

   // Next-state and next-digit logic; digit only changes on entry to an offer.
   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      case (state_q)
         IDLE: begin
            if (pend_any) begin
               digit_d = pend_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (ready) begin
               if (rem_any) begin
                  digit_d = rem_idx;
                  state_d = OFFER;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, digit, pending and overflow registers; reset discards everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         digit_q    <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         digit_q    <= digit_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
